// File: rtl/cr_irq_sequencer.sv
// cr_irq_sequencer
// Write-side controller for the 8-bit control register (CR). It merges software
// CR writes and ALU carry updates into the CR's single write port. It also
// sequences interrupt entry: save the CR into a shadow copy, then clear the
// paging and irq-enable bits. On return-from-interrupt it restores the CR from
// that shadow.
//
// Ports
//   clk         system clock, all state updates on posedge
//   reset       asynchronous active-low reset
//   cr_in       current CR value
//   irq_req     level interrupt request
//   reti        one-cycle return-from-interrupt pulse
//   sw_we       software write request, held by the requester until accepted
//   sw_mask     per-bit mask for the software write
//   sw_data     data for the software write
//   carry_we    one-cycle carry update from the ALU
//   carry_in    new carry value
//   cr_we_mask  per-bit CR write enable (registered)
//   cr_wdata    CR write data (registered)
//   cr_ce       CR write strobe (registered)
//   irq_ack     one-cycle pulse when interrupt entry is committed (registered)
//   in_isr      high while an interrupt is being serviced (registered)
//   busy        combinational, high when sw_we cannot be accepted this cycle
//   shadow      saved CR value (registered)
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | normal operation, passthrough writes, watch for irq
// ST_SAVE    | capture CR into shadow, software writes stalled
// ST_ENTER   | clear paging/irq-enable bits, pulse irq_ack
// ST_ISR     | servicing, passthrough writes, irq ignored, wait for reti
// ST_RESTORE | write shadow back into CR, leave the ISR

module cr_irq_sequencer #(
   parameter logic [7:0]  ENTRY_CLR_MASK = 8'h0C,
   parameter int unsigned IRQ_EN_BIT     = 3,
   parameter int unsigned CARRY_BIT      = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] cr_in,
   input  logic       irq_req,
   input  logic       reti,
   input  logic       sw_we,
   input  logic [7:0] sw_mask,
   input  logic [7:0] sw_data,
   input  logic       carry_we,
   input  logic       carry_in,
   output logic [7:0] cr_we_mask,
   output logic [7:0] cr_wdata,
   output logic       cr_ce,
   output logic       irq_ack,
   output logic       in_isr,
   output logic       busy,
   output logic [7:0] shadow
);

   localparam logic [7:0] CARRY_MASK  = 8'(1 << CARRY_BIT);
   localparam logic [7:0] IRQ_EN_MASK = 8'(1 << IRQ_EN_BIT);
   // MODE (bit 0) is read-only from this block's point of view.
   localparam logic [7:0] WRITABLE    = 8'hFE;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SAVE,
      ST_ENTER,
      ST_ISR,
      ST_RESTORE
   } state_t;

   state_t     state, state_nxt;
   logic [7:0] mask_nxt, data_nxt, shadow_nxt;
   logic       ce_nxt, ack_nxt, in_isr_nxt;

   logic [7:0] pt_mask, pt_data;
   logic       pt_ce;
   logic [7:0] c_mask, c_data;

   // Software write merged with a carry update. When the software mask already
   // covers the carry bit, the software value wins and the carry is dropped.
   always_comb begin
      pt_mask = 8'h00;
      pt_data = 8'h00;
      if (sw_we) begin
         pt_mask = sw_mask;
         pt_data = sw_data;
      end
      if (carry_we && !(sw_we && ((sw_mask & CARRY_MASK) != 8'h00))) begin
         pt_mask = pt_mask | CARRY_MASK;
         pt_data = carry_in ? (pt_data | CARRY_MASK) : (pt_data & ~CARRY_MASK);
      end
      pt_ce = sw_we | carry_we;
   end

   // Carry-only contribution, used while software writes are stalled.
   always_comb begin
      c_mask = carry_we ? CARRY_MASK : 8'h00;
      c_data = (carry_we && carry_in) ? CARRY_MASK : 8'h00;
   end

   always_comb begin
      state_nxt  = state;
      mask_nxt   = 8'h00;
      data_nxt   = 8'h00;
      ce_nxt     = 1'b0;
      ack_nxt    = 1'b0;
      in_isr_nxt = in_isr;
      shadow_nxt = shadow;
      busy       = 1'b0;
      unique case (state)
         ST_IDLE: begin
            mask_nxt = pt_mask;
            data_nxt = pt_data;
            ce_nxt   = pt_ce;
            if (irq_req && ((cr_in & IRQ_EN_MASK) != 8'h00)) begin
               state_nxt = ST_SAVE;
            end
         end
         ST_SAVE: begin
            // Any write issued on entry to this state has landed by now.
            busy       = 1'b1;
            mask_nxt   = c_mask;
            data_nxt   = c_data;
            ce_nxt     = carry_we;
            shadow_nxt = cr_in;
            state_nxt  = ST_ENTER;
         end
         ST_ENTER: begin
            busy       = 1'b1;
            mask_nxt   = ENTRY_CLR_MASK | c_mask;
            data_nxt   = c_data;
            ce_nxt     = 1'b1;
            ack_nxt    = 1'b1;
            in_isr_nxt = 1'b1;
            state_nxt  = ST_ISR;
         end
         ST_ISR: begin
            if (reti) begin
               busy      = 1'b1;
               state_nxt = ST_RESTORE;
            end else begin
               mask_nxt = pt_mask;
               data_nxt = pt_data;
               ce_nxt   = pt_ce;
            end
         end
         ST_RESTORE: begin
            // Carry updates are dropped here; the pre-interrupt carry comes back.
            busy       = 1'b1;
            mask_nxt   = WRITABLE;
            data_nxt   = shadow;
            ce_nxt     = 1'b1;
            in_isr_nxt = 1'b0;
            state_nxt  = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         cr_we_mask <= 8'h00;
         cr_wdata   <= 8'h00;
         cr_ce      <= 1'b0;
         irq_ack    <= 1'b0;
         in_isr     <= 1'b0;
         shadow     <= 8'h00;
      end else begin
         state      <= state_nxt;
         cr_we_mask <= mask_nxt & WRITABLE;
         cr_wdata   <= data_nxt;
         cr_ce      <= ce_nxt;
         irq_ack    <= ack_nxt;
         in_isr     <= in_isr_nxt;
         shadow     <= shadow_nxt;
      end
   end

endmodule

// File: doc/cr_irq_sequencer.md
Name: cr_irq_sequencer

Overview:
- Writer-side partner of the 8-bit control register.
- Sole source of that register's write-mask, write-data and clock-enable inputs.
- Merges software control-register writes and ALU carry updates into one write port.
- Sequences interrupt entry (save CR, clear paging and irq enable) and return-from-interrupt (restore CR from a shadow copy).

Parameters:
- ENTRY_CLR_MASK, 8'h0C, CR bits cleared on interrupt entry (bit 2 paging, bit 3 irq enable).
- IRQ_EN_BIT, 3, index of the irq-enable bit in the CR.
- CARRY_BIT, 1, index of the carry bit in the CR.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- cr_in  in  8  current control register value.
- irq_req  in  1  level interrupt request.
- reti  in  1  one-cycle pulse from the decoder: return from interrupt.
- sw_we  in  1  software CR write request; held until accepted.
- sw_mask  in  8  per-bit write mask for the software write.
- sw_data  in  8  data for the software write.
- carry_we  in  1  one-cycle carry update from the ALU.
- carry_in  in  1  new carry value.
- cr_we_mask  out  8  per-bit write enable to the control register.
- cr_wdata  out  8  write data to the control register.
- cr_ce  out  1  control register write enable.
- irq_ack  out  1  one-cycle pulse when interrupt entry is committed.
- in_isr  out  1  high while servicing an interrupt.
- busy  out  1  high when a software write cannot be accepted this cycle.
- shadow  out  8  saved CR value, for debug.

Behaviour:
- Reset (reset=0, async):
  - State IDLE.
  - cr_we_mask, cr_wdata, shadow = 8'h00; cr_ce, irq_ack, in_isr = 0.
  - busy = 0.
- Write timing:
  - All outputs are registered.
  - A request sampled at posedge N drives cr_ce/mask/data from posedge N to N+1.
  - The control register captures that write on the intervening negedge.
  - Latency: 1 cycle.
- Default cycle: cr_ce = 0 and cr_we_mask = 0 unless a write is issued.
- Bit 0 (MODE) is never written: cr_we_mask[0] is forced to 0 on every path.
- Passthrough merge (states IDLE, ISR):
  - sw_we accepted when busy=0: mask = sw_mask & 8'hFE, data = sw_data.
  - carry_we: sets mask[CARRY_BIT] and data[CARRY_BIT] = carry_in.
  - If sw_we and carry_we coincide and sw_mask[CARRY_BIT]=1, the software value wins on that bit; the carry update is dropped.
  - cr_ce = 1 if either request is present.
- States:
  - IDLE:
    - irq_req=1 and cr_in[IRQ_EN_BIT]=1 -> SAVE.
    - A passthrough write in the same cycle is still issued.
  - SAVE:
    - shadow <= cr_in, sampled after any write issued in the prior cycle has landed.
    - busy = 1; sw_we is not accepted, so the requester holds it.
    - carry_we is merged as a passthrough write.
    - Next state: ENTER.
  - ENTER, one cycle:
    - Issue mask = ENTRY_CLR_MASK, data = 8'h00, cr_ce = 1.
    - A coincident carry_we is merged on CARRY_BIT.
    - irq_ack = 1 for exactly this cycle; in_isr <= 1; busy = 1.
    - Next state: ISR.
  - ISR:
    - Passthrough as in IDLE.
    - irq_req is ignored, so interrupts never nest.
    - reti=1 -> RESTORE; any coincident sw_we or carry_we is not accepted. busy goes high combinationally.
  - RESTORE, one cycle:
    - Issue mask = 8'hFE, data = shadow, cr_ce = 1.
    - carry_we in this cycle is dropped, because the pre-interrupt carry is restored.
    - in_isr <= 0; busy = 1.
    - Next state: IDLE.
- busy: combinational; 1 in SAVE, ENTER, RESTORE, and in ISR when reti=1.
- reti in IDLE, SAVE or ENTER: ignored, no write.
- irq_req deasserting during SAVE: entry still completes (committed once SAVE is entered).
- Reset mid-ENTER or mid-RESTORE:
  - Outputs clear immediately; no partial write is issued after reset.
  - The control register is re-initialised by its own reset.

Test Plan:
- Reset, then software write sw_mask=8'hFF, sw_data=8'hA5 in IDLE -> one cycle later cr_ce=1, cr_we_mask=8'hFE, cr_wdata=8'hA5; next cycle cr_ce=0.
- cr_in=8'h0F, irq_req=1 -> SAVE (shadow=8'h0F); then ENTER with cr_we_mask=8'h0C, cr_wdata=8'h00, irq_ack pulse; in_isr=1.
- In ISR, carry_we=1 with carry_in=1 -> mask=8'h02, data=8'h02. Then reti -> RESTORE with mask=8'hFE, data=8'h0F; in_isr=0; state IDLE.
- irq_req=1 with cr_in[3]=0 -> no entry, irq_ack stays 0. reti in IDLE -> cr_ce stays 0.
- sw_we held across SAVE/ENTER -> busy=1 for 2 cycles, write issued in the first ISR cycle. carry_we+sw_we with sw_mask[1]=1, sw_data[1]=0, carry_in=1 -> data[1]=0.
- Assert reset low during ENTER -> cr_ce=0, irq_ack=0, in_isr=0 immediately; after release, state IDLE, shadow=8'h00.
